// File: rtl/gpio_int_rst_seq_if.sv
// Control/status bundle between the reset sequencer and its software/board side.
interface gpio_int_rst_seq_if #(
    parameter int P_RST_NUM = 4
);
    logic [P_RST_NUM-1:0] i_sw_rst_req;
    logic                 i_hold;
    logic [P_RST_NUM-1:0] o_rstn;
    logic                 o_rst_done;
    logic [1:0]           o_state;

    modport master (
        output i_sw_rst_req, i_hold,
        input  o_rstn, o_rst_done, o_state
    );

    modport slave (
        input  i_sw_rst_req, i_hold,
        output o_rstn, o_rst_done, o_state
    );
endinterface

// File: rtl/gpio_int_rst_seq.sv
// Staggered release of P_RST_NUM local resets after a synchronised board reset,
// with per-channel software re-pulse once the sequence has finished.
//
// state  | meaning
// ASSERT | all outputs held in reset, waiting for synchronised release
// WAIT   | releasing channels one by one, P_STEP_DLY cycles apart
// DONE   | all released; software pulses serviced here
module gpio_int_rst_seq #(
    parameter int P_RST_NUM     = 4,
    parameter int P_SYNC_STAGES = 2,
    parameter int P_STEP_DLY    = 16,
    parameter int P_SW_PULSE    = 32
) (
    input logic              clk_50m,
    input logic              rstn_50m,
    gpio_int_rst_seq_if.slave bus
);
    localparam int CW = $clog2((P_STEP_DLY > P_SW_PULSE) ? P_STEP_DLY : P_SW_PULSE) + 1;
    localparam int IW = $clog2(P_RST_NUM) + 1;

    localparam logic [1:0] ST_ASSERT = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [P_SYNC_STAGES-1:0]         sync_q, sync_d;
    logic                             s_rstn_syn;
    logic [1:0]                       state_q, state_d;
    logic [CW-1:0]                    step_cnt_q, step_cnt_d;
    logic [IW-1:0]                    idx_q, idx_d;
    logic [P_RST_NUM-1:0]             rstn_q, rstn_d;
    logic [P_RST_NUM-1:0]             req_prev_q, req_prev_d;
    logic [P_RST_NUM-1:0]             req_rise;
    logic [P_RST_NUM-1:0][CW-1:0]     sw_cnt_q, sw_cnt_d;
    logic                             done_q, done_d;

    assign s_rstn_syn = sync_q[P_SYNC_STAGES-1];
    assign sync_d     = {sync_q[P_SYNC_STAGES-2:0], 1'b1};
    assign req_prev_d = bus.i_sw_rst_req;
    assign req_rise   = bus.i_sw_rst_req & ~req_prev_q;

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        idx_d      = idx_q;
        rstn_d     = rstn_q;
        sw_cnt_d   = sw_cnt_q;
        case (state_q)
            ST_ASSERT: begin
                rstn_d = '0;
                if (s_rstn_syn) begin
                    state_d    = ST_WAIT;
                    step_cnt_d = '0;
                    idx_d      = '0;
                end
            end
            ST_WAIT: begin
                if (!bus.i_hold) begin
                    if (step_cnt_q == CW'(P_STEP_DLY - 1)) begin
                        step_cnt_d = '0;
                        idx_d      = idx_q + 1'b1;
                        rstn_d     = rstn_q | (P_RST_NUM'(1) << idx_q);
                        if (idx_q == IW'(P_RST_NUM - 1)) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Down-counters; a new rising edge reloads, which stretches a live pulse.
                for (int k = 0; k < P_RST_NUM; k++) begin
                    if (req_rise[k]) begin
                        sw_cnt_d[k] = CW'(P_SW_PULSE);
                        rstn_d[k]   = 1'b0;
                    end else if (sw_cnt_q[k] == CW'(1)) begin
                        sw_cnt_d[k] = '0;
                        rstn_d[k]   = 1'b1;
                    end else if (sw_cnt_q[k] != '0) begin
                        sw_cnt_d[k] = sw_cnt_q[k] - 1'b1;
                    end
                end
            end
            default: state_d = ST_ASSERT;
        endcase
    end

    assign done_d = (state_q == ST_DONE) && (sw_cnt_d == '0);

    always_ff @(posedge clk_50m or negedge rstn_50m) begin
        if (!rstn_50m) begin
            sync_q     <= '0;
            state_q    <= ST_ASSERT;
            step_cnt_q <= '0;
            idx_q      <= '0;
            rstn_q     <= '0;
            req_prev_q <= '0;
            sw_cnt_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            idx_q      <= idx_d;
            rstn_q     <= rstn_d;
            req_prev_q <= req_prev_d;
            sw_cnt_q   <= sw_cnt_d;
            done_q     <= done_d;
        end
    end

    assign bus.o_rstn     = rstn_q;
    assign bus.o_rst_done = done_q;
    assign bus.o_state    = state_q;
endmodule
